// File: rtl/page_table_walker.sv
// Two-level page table walker: reads the PDE then the PTE on a TLB miss and
// fills the TLB, with a per-read bus timeout and a flush-driven abort path.
module page_table_walker #(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int ASID_WIDTH     = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  miss_valid,
   output logic                  miss_ready,
   input  logic [19:0]           miss_vpage_idx,
   input  logic [ASID_WIDTH-1:0] miss_asid,
   input  logic [19:0]           page_dir_base,
   input  logic                  flush_en,
   output logic                  mem_read_en,
   output logic [31:0]           mem_addr,
   input  logic                  mem_read_ack,
   input  logic [31:0]           mem_read_data,
   output logic                  tlb_update_en,
   output logic [19:0]           tlb_vpage_idx,
   output logic [19:0]           tlb_ppage_idx,
   output logic [ASID_WIDTH-1:0] tlb_asid,
   output logic                  tlb_present,
   output logic                  tlb_exe_writable,
   output logic                  tlb_supervisor,
   output logic                  tlb_global,
   output logic                  walk_done,
   output logic [1:0]            walk_fault
);
   localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [1:0]       FAULT_NONE = 2'd0;
   localparam logic [1:0]       FAULT_PDE  = 2'd1;
   localparam logic [1:0]       FAULT_BUS  = 2'd2;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      READ_PDE = 3'd1,
      READ_PTE = 3'd2,
      FILL     = 3'd3,
      DONE     = 3'd4
   } state_t;

   state_t                state_r, state_s;
   logic [19:0]           vpage_r, vpage_s;
   logic [ASID_WIDTH-1:0] asid_r, asid_s;
   logic [19:0]           base_r, base_s;
   logic [19:0]           pde_r, pde_s;
   logic [19:0]           ppage_r, ppage_s;
   logic [3:0]            attr_r, attr_s;
   logic [CNT_W-1:0]      cnt_r, cnt_s;
   logic                  abort_r, abort_s;
   logic [1:0]            fault_r, fault_s;
   logic                  abort_now_s;
   logic                  unused_data_s;

   // PTE bits 11:4 carry nothing the TLB stores
   assign unused_data_s = ^mem_read_data[11:4];
   assign abort_now_s   = abort_r | flush_en;

   // Next-state and next-field computation
   always_comb begin
      state_s = state_r;
      vpage_s = vpage_r;
      asid_s  = asid_r;
      base_s  = base_r;
      pde_s   = pde_r;
      ppage_s = ppage_r;
      attr_s  = attr_r;
      cnt_s   = cnt_r;
      abort_s = abort_r;
      fault_s = fault_r;
      case (state_r)
         IDLE: begin
            abort_s = 1'b0;
            if (miss_valid && !flush_en) begin
               vpage_s = miss_vpage_idx;
               asid_s  = miss_asid;
               base_s  = page_dir_base;
               cnt_s   = CNT_ZERO;
               fault_s = FAULT_NONE;
               state_s = READ_PDE;
            end else begin
               state_s = IDLE;
            end
         end
         READ_PDE: begin
            abort_s = abort_now_s;
            cnt_s   = cnt_r + CNT_ONE;
            if (mem_read_ack) begin
               cnt_s = CNT_ZERO;
               if (abort_now_s) begin
                  state_s = IDLE;
               end else if (!mem_read_data[0]) begin
                  fault_s = FAULT_PDE;
                  state_s = DONE;
               end else begin
                  pde_s   = mem_read_data[31:12];
                  state_s = READ_PTE;
               end
            end else if (cnt_r == CNT_LAST) begin
               fault_s = FAULT_BUS;
               state_s = abort_now_s ? IDLE : DONE;
            end else begin
               state_s = READ_PDE;
            end
         end
         READ_PTE: begin
            abort_s = abort_now_s;
            cnt_s   = cnt_r + CNT_ONE;
            if (mem_read_ack) begin
               cnt_s   = CNT_ZERO;
               ppage_s = mem_read_data[31:12];
               attr_s  = mem_read_data[3:0];
               state_s = abort_now_s ? IDLE : FILL;
            end else if (cnt_r == CNT_LAST) begin
               fault_s = FAULT_BUS;
               state_s = abort_now_s ? IDLE : DONE;
            end else begin
               state_s = READ_PTE;
            end
         end
         FILL: begin
            if (flush_en) begin
               state_s = IDLE;
            end else begin
               fault_s = FAULT_NONE;
               state_s = DONE;
            end
         end
         DONE: begin
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State and latched walk context
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= IDLE;
         vpage_r <= 20'h0_0000;
         asid_r  <= {ASID_WIDTH{1'b0}};
         base_r  <= 20'h0_0000;
         pde_r   <= 20'h0_0000;
         ppage_r <= 20'h0_0000;
         attr_r  <= 4'h0;
         cnt_r   <= CNT_ZERO;
         abort_r <= 1'b0;
         fault_r <= FAULT_NONE;
      end else begin
         state_r <= state_s;
         vpage_r <= vpage_s;
         asid_r  <= asid_s;
         base_r  <= base_s;
         pde_r   <= pde_s;
         ppage_r <= ppage_s;
         attr_r  <= attr_s;
         cnt_r   <= cnt_s;
         abort_r <= abort_s;
         fault_r <= fault_s;
      end
   end

   // Output decode; the fill strobe is gated by a same-cycle flush
   always_comb begin
      miss_ready    = 1'b0;
      mem_read_en   = 1'b0;
      mem_addr      = 32'h0000_0000;
      tlb_update_en = 1'b0;
      walk_done     = 1'b0;
      walk_fault    = FAULT_NONE;
      case (state_r)
         IDLE: begin
            miss_ready = 1'b1;
         end
         READ_PDE: begin
            mem_read_en = 1'b1;
            mem_addr    = {base_r, vpage_r[19:10], 2'b00};
         end
         READ_PTE: begin
            mem_read_en = 1'b1;
            mem_addr    = {pde_r, vpage_r[9:0], 2'b00};
         end
         FILL: begin
            tlb_update_en = !flush_en;
         end
         DONE: begin
            walk_done  = 1'b1;
            walk_fault = fault_r;
         end
         default: begin
            miss_ready = 1'b0;
         end
      endcase
   end

   assign tlb_vpage_idx    = vpage_r;
   assign tlb_asid         = asid_r;
   assign tlb_ppage_idx    = ppage_r;
   assign tlb_present      = attr_r[0];
   assign tlb_exe_writable = attr_r[1];
   assign tlb_supervisor   = attr_r[2];
   assign tlb_global       = attr_r[3];

endmodule

// File: tb/tb_page_table_walker.sv
// Directed bench for page_table_walker: table of complete walks plus
// hand-written flush, timeout, back-to-back and reset sequences.
module tb_page_table_walker;
   localparam int AW = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          miss_valid;
   logic          miss_ready;
   logic [19:0]   miss_vpage_idx;
   logic [AW-1:0] miss_asid;
   logic [19:0]   page_dir_base;
   logic          flush_en;
   logic          mem_read_en;
   logic [31:0]   mem_addr;
   logic          mem_read_ack;
   logic [31:0]   mem_read_data;
   logic          tlb_update_en;
   logic [19:0]   tlb_vpage_idx;
   logic [19:0]   tlb_ppage_idx;
   logic [AW-1:0] tlb_asid;
   logic          tlb_present, tlb_exe_writable, tlb_supervisor, tlb_global;
   logic          walk_done;
   logic [1:0]    walk_fault;

   int checks = 0;
   int errors = 0;
   int fill_cnt = 0;
   int done_cnt = 0;

   always #5 clk = ~clk;

   page_table_walker #(.TIMEOUT_CYCLES(4), .ASID_WIDTH(AW)) dut (
      .clk(clk), .reset(reset),
      .miss_valid(miss_valid), .miss_ready(miss_ready),
      .miss_vpage_idx(miss_vpage_idx), .miss_asid(miss_asid),
      .page_dir_base(page_dir_base), .flush_en(flush_en),
      .mem_read_en(mem_read_en), .mem_addr(mem_addr),
      .mem_read_ack(mem_read_ack), .mem_read_data(mem_read_data),
      .tlb_update_en(tlb_update_en), .tlb_vpage_idx(tlb_vpage_idx),
      .tlb_ppage_idx(tlb_ppage_idx), .tlb_asid(tlb_asid),
      .tlb_present(tlb_present), .tlb_exe_writable(tlb_exe_writable),
      .tlb_supervisor(tlb_supervisor), .tlb_global(tlb_global),
      .walk_done(walk_done), .walk_fault(walk_fault)
   );

   // Pulse counters sampled mid-cycle
   always @(negedge clk) begin
      if (tlb_update_en) fill_cnt++;
      if (walk_done) done_cnt++;
   end

   typedef struct {
      logic [19:0]   vpage;
      logic [AW-1:0] asid;
      logic [19:0]   base;
      logic [31:0]   pde;
      logic [31:0]   pte;
      int            pde_wait;
      int            pte_wait;
      logic [31:0]   pde_addr;
      logic [31:0]   pte_addr;
      logic [1:0]    fault;
      logic [19:0]   ppage;
      logic [3:0]    attr;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #2;
      mem_read_ack  = 1'b0;
      mem_read_data = 32'h0;
   endtask

   task automatic start_req(input vec_t v);
      miss_vpage_idx = v.vpage;
      miss_asid      = v.asid;
      page_dir_base  = v.base;
      miss_valid     = 1'b1;
      #1;
      chk("accept_ready", 32'(miss_ready), 32'd1);
      next_cycle();
      miss_valid = 1'b0;
   endtask

   task automatic run_walk(input vec_t v);
      start_req(v);
      for (int k = 0; k <= v.pde_wait; k++) begin
         if (k == v.pde_wait) begin
            mem_read_ack  = 1'b1;
            mem_read_data = v.pde;
         end
         #1;
         chk("pde_en", 32'(mem_read_en), 32'd1);
         chk("pde_addr", mem_addr, v.pde_addr);
         chk("pde_busy", 32'(miss_ready), 32'd0);
         next_cycle();
      end
      if (v.fault == 2'd0) begin
         for (int k = 0; k <= v.pte_wait; k++) begin
            if (k == v.pte_wait) begin
               mem_read_ack  = 1'b1;
               mem_read_data = v.pte;
            end
            #1;
            chk("pte_en", 32'(mem_read_en), 32'd1);
            chk("pte_addr", mem_addr, v.pte_addr);
            next_cycle();
         end
         #1;
         chk("fill_en", 32'(tlb_update_en), 32'd1);
         chk("fill_vpage", 32'(tlb_vpage_idx), 32'(v.vpage));
         chk("fill_asid", 32'(tlb_asid), 32'(v.asid));
         chk("fill_ppage", 32'(tlb_ppage_idx), 32'(v.ppage));
         chk("fill_attr", 32'({tlb_global, tlb_supervisor, tlb_exe_writable, tlb_present}), 32'(v.attr));
         chk("fill_addr0", mem_addr, 32'h0);
         next_cycle();
      end
      #1;
      chk("done", 32'(walk_done), 32'd1);
      chk("done_fault", 32'(walk_fault), 32'(v.fault));
      chk("done_noread", 32'(mem_read_en), 32'd0);
      chk("done_nofill", 32'(tlb_update_en), 32'd0);
      next_cycle();
      #1;
      chk("idle_ready", 32'(miss_ready), 32'd1);
      chk("idle_nodone", 32'(walk_done), 32'd0);
   endtask

   initial begin
      int f0, d0;
      // PTE word index is vpage[9:0]: 0x4557b -> 0x17b -> byte offset 0x5ec
      vecs[0] = '{20'h4557b, 8'h03, 20'h00010, 32'h0002_0001, 32'hd32e_b00f, 0, 0,
                  32'h0001_0454, 32'h0002_05ec, 2'd0, 20'hd32eb, 4'hf};
      vecs[1] = '{20'h4557b, 8'h03, 20'h00010, 32'h0002_0000, 32'h0, 0, 0,
                  32'h0001_0454, 32'h0, 2'd1, 20'h0, 4'h0};
      vecs[2] = '{20'h4557b, 8'h03, 20'h00010, 32'h0002_0001, 32'hcccc_c000, 0, 0,
                  32'h0001_0454, 32'h0002_05ec, 2'd0, 20'hccccc, 4'h0};
      // PTE ack lands on the last allowed cycle: ack must win
      vecs[3] = '{20'hfffff, 8'ha5, 20'habcde, 32'h1234_5001, 32'h0000_100a, 2, 3,
                  32'habcd_effc, 32'h1234_5ffc, 2'd0, 20'h00001, 4'ha};
      vecs[4] = '{20'h00000, 8'h00, 20'h00000, 32'hffff_f001, 32'hffff_f005, 1, 0,
                  32'h0000_0000, 32'hffff_f000, 2'd0, 20'hfffff, 4'h5};
      vecs[5] = '{20'h80200, 8'h7f, 20'h00400, 32'h0080_0003, 32'h5555_5006, 0, 1,
                  32'h0040_0800, 32'h0080_0800, 2'd0, 20'h55555, 4'h6};

      reset = 1'b1; miss_valid = 1'b0; miss_vpage_idx = 20'h0; miss_asid = 8'h0;
      page_dir_base = 20'h0; flush_en = 1'b0; mem_read_ack = 1'b0; mem_read_data = 32'h0;
      #3;
      chk("rst_ready", 32'(miss_ready), 32'd1);
      chk("rst_en", 32'(mem_read_en), 32'd0);
      chk("rst_addr", mem_addr, 32'h0);
      chk("rst_fill", 32'(tlb_update_en), 32'd0);
      chk("rst_done", 32'(walk_done), 32'd0);
      chk("rst_fault", 32'(walk_fault), 32'd0);
      @(posedge clk); #2; reset = 1'b0;

      for (int i = 0; i < 6; i++) run_walk(vecs[i]);

      // Bus timeout in READ_PDE
      start_req(vecs[4]);
      for (int k = 0; k < 4; k++) begin
         #1; chk("to_en", 32'(mem_read_en), 32'd1);
         next_cycle();
      end
      #1;
      chk("to_done", 32'(walk_done), 32'd1);
      chk("to_fault", 32'(walk_fault), 32'd2);
      chk("to_en_drop", 32'(mem_read_en), 32'd0);
      chk("to_addr0", mem_addr, 32'h0);
      next_cycle(); #1;
      chk("to_idle", 32'(miss_ready), 32'd1);

      // Flush during READ_PTE, ack three cycles later
      f0 = fill_cnt; d0 = done_cnt;
      start_req(vecs[0]);
      mem_read_ack = 1'b1; mem_read_data = vecs[0].pde; #1; next_cycle();
      flush_en = 1'b1; #1;
      chk("fl_pte_en", 32'(mem_read_en), 32'd1);
      next_cycle(); flush_en = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         if (k == 3) begin mem_read_ack = 1'b1; mem_read_data = vecs[0].pte; end
         #1; chk("fl_hold", 32'(mem_read_en), 32'd1);
         next_cycle();
      end
      #1;
      chk("fl_ready", 32'(miss_ready), 32'd1);
      chk("fl_nodone", 32'(walk_done), 32'd0);
      next_cycle(); #1;
      chk("fl_fills", fill_cnt - f0, 32'd0);
      chk("fl_dones", done_cnt - d0, 32'd0);

      // Flush during READ_PDE with no ack: timeout path returns silently
      d0 = done_cnt;
      start_req(vecs[0]);
      flush_en = 1'b1; #1; next_cycle(); flush_en = 1'b0;
      for (int k = 1; k < 4; k++) begin #1; next_cycle(); end
      #1;
      chk("flto_ready", 32'(miss_ready), 32'd1);
      next_cycle(); #1;
      chk("flto_dones", done_cnt - d0, 32'd0);

      // Flush in FILL suppresses the strobe and skips DONE
      start_req(vecs[2]);
      mem_read_ack = 1'b1; mem_read_data = vecs[2].pde; #1; next_cycle();
      mem_read_ack = 1'b1; mem_read_data = vecs[2].pte; #1; next_cycle();
      flush_en = 1'b1; #1;
      chk("ffill_upd", 32'(tlb_update_en), 32'd0);
      next_cycle(); flush_en = 1'b0; #1;
      chk("ffill_ready", 32'(miss_ready), 32'd1);
      chk("ffill_nodone", 32'(walk_done), 32'd0);
      next_cycle();

      // Flush in IDLE blocks acceptance
      miss_valid = 1'b1; flush_en = 1'b1; #1; next_cycle();
      miss_valid = 1'b0; flush_en = 1'b0; #1;
      chk("fidle_en", 32'(mem_read_en), 32'd0);
      chk("fidle_ready", 32'(miss_ready), 32'd1);
      next_cycle();

      // Back-to-back: second request held through the first walk
      f0 = fill_cnt;
      miss_vpage_idx = vecs[0].vpage; miss_asid = vecs[0].asid;
      page_dir_base = vecs[0].base; miss_valid = 1'b1; #1; next_cycle();
      miss_vpage_idx = vecs[5].vpage; miss_asid = vecs[5].asid; page_dir_base = vecs[5].base;
      mem_read_ack = 1'b1; mem_read_data = vecs[0].pde; #1;
      chk("b2b_pde1", mem_addr, vecs[0].pde_addr);
      next_cycle();
      mem_read_ack = 1'b1; mem_read_data = vecs[0].pte; #1;
      chk("b2b_pte1", mem_addr, vecs[0].pte_addr);
      next_cycle(); #1;
      chk("b2b_fill1", 32'(tlb_vpage_idx), 32'h4557b);
      chk("b2b_busy", 32'(miss_ready), 32'd0);
      next_cycle(); #1;
      chk("b2b_done1", 32'(walk_done), 32'd1);
      next_cycle(); #1;
      chk("b2b_accept2", 32'(miss_ready), 32'd1);
      next_cycle(); miss_valid = 1'b0;
      mem_read_ack = 1'b1; mem_read_data = vecs[5].pde; #1;
      chk("b2b_pde2", mem_addr, vecs[5].pde_addr);
      next_cycle();
      mem_read_ack = 1'b1; mem_read_data = vecs[5].pte; #1; next_cycle(); #1;
      chk("b2b_fill2", 32'(tlb_vpage_idx), 32'h80200);
      chk("b2b_ppage2", 32'(tlb_ppage_idx), 32'h55555);
      next_cycle(); #1;
      chk("b2b_done2", 32'(walk_done), 32'd1);
      chk("b2b_fills", fill_cnt - f0, 32'd2);
      next_cycle();

      // Reset mid-walk, then a stale ack
      f0 = fill_cnt; d0 = done_cnt;
      start_req(vecs[0]);
      mem_read_ack = 1'b1; mem_read_data = vecs[0].pde; #1; next_cycle();
      reset = 1'b1; #1;
      chk("mrst_ready", 32'(miss_ready), 32'd1);
      chk("mrst_en", 32'(mem_read_en), 32'd0);
      chk("mrst_addr", mem_addr, 32'h0);
      next_cycle(); reset = 1'b0;
      mem_read_ack = 1'b1; mem_read_data = vecs[0].pte; #1; next_cycle(); #1;
      chk("mrst_stale_en", 32'(mem_read_en), 32'd0);
      chk("mrst_stale_upd", 32'(tlb_update_en), 32'd0);
      next_cycle(); #1;
      chk("mrst_fills", fill_cnt - f0, 32'd0);
      chk("mrst_dones", done_cnt - d0, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
